pcpi_div_arbiter: RTL and testbench

//  Shares one PCPI divider unit (DIV/DIVU/REM/REMU) between NREQ PCPI requesters (cores or PCPI masters).
//  Pre-decodes each requester's instruction and grants the divider round-robin.

---
 rtl/pcpi_div_pkg.sv | 20 ++
 rtl/pcpi_rr_arbiter.sv | 34 +++
 rtl/pcpi_div_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_pcpi_div_arbiter.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_div_pkg.sv
// Shared definitions for the PCPI divider arbiter: opcode constants, the
// arbiter FSM state type and the DIV/DIVU/REM/REMU pre-decode.
package pcpi_div_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // M-extension ops with funct3[2] set are the four divide/remainder variants
  function automatic logic is_divrem(input logic [31:0] insn);
    return (insn[6:0] == OPC_OP) && (insn[31:25] == F7_MULDIV) && insn[14];
  endfunction

endpackage

// File: rtl/pcpi_rr_arbiter.sv
// NREQ-way round-robin picker: the lowest requesting index at or after ptr
// (wrapping) wins. Purely combinational; the caller owns the pointer.
module pcpi_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);

  // scan NREQ positions starting at ptr, first hit wins
  always_comb begin
    int pos;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    pos     = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!any && req[j] && (j == pos)) begin
          any     = 1'b1;
          gnt[j]  = 1'b1;
          gnt_idx = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/pcpi_div_arbiter.sv
// Shares one PCPI divider between NREQ PCPI requesters. Each requester's
// instruction is pre-decoded; divide/remainder ops are granted round-robin,
// operands are frozen on the divider port for the whole divide and the result
// is returned to the owner as a one-cycle ready/wr pulse.
//
// Optional build macro: PCPI_DIV_ARB_STATS_EN adds saturating statistics
// outputs stat_grants (16 bits per requester, completed grants) and
// stat_busy (cycles spent outside IDLE).
//
// state | meaning
// IDLE  | divider free; grant the round-robin winner and launch div_valid
// ISSUE | div_valid high, waiting for the divider to raise div_wait
// BUSY  | divide in progress, waiting for div_ready
// DONE  | result pulse to the owner (unless aborted), pointer advances
module pcpi_div_arbiter
  import pcpi_div_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int RR_INIT = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_insn,
  input  logic [32*NREQ-1:0]   req_rs1,
  input  logic [32*NREQ-1:0]   req_rs2,
  output logic [NREQ-1:0]      req_wait,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      req_wr,
  output logic [31:0]          req_rd,
  output logic                 div_valid,
  output logic [31:0]          div_insn,
  output logic [31:0]          div_rs1,
  output logic [31:0]          div_rs2,
  input  logic                 div_wait,
  input  logic                 div_ready,
  input  logic                 div_wr,
  input  logic [31:0]          div_rd
`ifdef PCPI_DIV_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0]   stat_grants,
  output logic [31:0]          stat_busy
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t       state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    ptr_next;
  logic             aborted;
  logic             abort_now;
  logic             owner_valid;
  logic [NREQ-1:0]  is_div;
  logic [NREQ-1:0]  owner_oh;
  logic [NREQ-1:0]  gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [31:0]      sel_insn;
  logic [31:0]      sel_rs1;
  logic [31:0]      sel_rs2;

  // pre-decode every requester
  always_comb begin
    is_div = '0;
    for (int i = 0; i < NREQ; i++) begin
      is_div[i] = req_valid[i] & is_divrem(req_insn[32*i +: 32]);
    end
  end

  pcpi_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req     (is_div),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // operand mux for the winner, only sampled in IDLE
  always_comb begin
    sel_insn = '0;
    sel_rs1  = '0;
    sel_rs2  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_insn = req_insn[32*i +: 32];
        sel_rs1  = req_rs1[32*i +: 32];
        sel_rs2  = req_rs2[32*i +: 32];
      end
    end
  end

  // owner decode and abort detection (owner dropping pcpi_valid mid-divide)
  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      owner_oh[i] = (owner == IW'(i));
    end
    owner_valid = |(owner_oh & req_valid);
    abort_now   = aborted | ~owner_valid;
  end

  // pointer moves one past the owner, wrapping at NREQ
  always_comb begin
    if (owner == IW'(NREQ - 1)) ptr_next = '0;
    else                        ptr_next = owner + IW'(1);
  end

  // queued and granted requesters keep waiting until their DONE cycle
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_wait[i] = resetn & is_div[i] & ~((state == DONE) & owner_oh[i]);
    end
  end

  // arbiter FSM with registered divider-side and result outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= IW'(RR_INIT);
      aborted   <= 1'b0;
      div_valid <= 1'b0;
      div_insn  <= '0;
      div_rs1   <= '0;
      div_rs2   <= '0;
      req_ready <= '0;
      req_wr    <= '0;
      req_rd    <= '0;
    end else begin
      req_ready <= '0;
      req_wr    <= '0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            owner     <= gnt_idx;
            div_insn  <= sel_insn;
            div_rs1   <= sel_rs1;
            div_rs2   <= sel_rs2;
            div_valid <= 1'b1;
            aborted   <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          aborted <= abort_now;
          if (div_wait) state <= BUSY;
        end
        BUSY: begin
          aborted <= abort_now;
          if (div_ready) begin
            div_valid <= 1'b0;
            if (!abort_now) begin
              req_rd    <= div_rd;
              req_ready <= owner_oh;
              req_wr    <= div_wr ? owner_oh : '0;
            end
            state <= DONE;
          end
        end
        DONE: begin
          ptr   <= ptr_next;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PCPI_DIV_ARB_STATS_EN
  // saturating per-requester completion counters and busy-cycle counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_grants <= '0;
      stat_busy   <= '0;
    end else begin
      if ((state != IDLE) && (stat_busy != 32'hFFFF_FFFF)) stat_busy <= stat_busy + 32'd1;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && (stat_grants[16*i +: 16] != 16'hFFFF)) begin
          stat_grants[16*i +: 16] <= stat_grants[16*i +: 16] + 16'd1;
        end
      end
    end
  end
`else
  // statistics counters are not built in this configuration
`endif

  // a result from the divider is only legal while a divide is outstanding
  always_ff @(posedge clk) begin
    if (resetn && div_ready) begin
      assert (state == BUSY) else $error("pcpi_div_arbiter: div_ready outside BUSY");
    end
  end

endmodule

// File: tb/tb_pcpi_div_arbiter.sv
// Bench for pcpi_div_arbiter: random divide traffic from three requesters,
// a behavioural PCPI divider, and a reference model of grant order, result
// values and wait/ready timing.
module tb_pcpi_div_arbiter;

  localparam int NREQ    = 3;
  localparam int RR_INIT = 0;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_insn;
  logic [32*NREQ-1:0]  req_rs1;
  logic [32*NREQ-1:0]  req_rs2;
  logic [NREQ-1:0]     req_wait;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     req_wr;
  logic [31:0]         req_rd;
  logic                div_valid;
  logic [31:0]         div_insn;
  logic [31:0]         div_rs1;
  logic [31:0]         div_rs2;
  logic                div_wait;
  logic                div_ready;
  logic                div_wr;
  logic [31:0]         div_rd;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          m_ptr;
  int          m_owner;
  bit          m_active;
  bit          m_aborted;
  bit          m_done_exp;
  bit          prev_dv;
  logic [31:0] lat_insn, lat_rs1, lat_rs2;
  logic [31:0] req_exp [NREQ];
  int          comp_q[$];
  logic [31:0] comp_rd[$];
  int          grant_q[$];

  // behavioural divider state
  bit          dm_busy;
  bit          dm_rdy;
  int          dm_cnt;
  int          dm_force = -1;
  logic [31:0] dm_insn, dm_a, dm_b;

  pcpi_div_arbiter #(
    .NREQ    (NREQ),
    .RR_INIT (RR_INIT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_insn  (req_insn),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_wait  (req_wait),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_rd    (req_rd),
    .div_valid (div_valid),
    .div_insn  (div_insn),
    .div_rs1   (div_rs1),
    .div_rs2   (div_rs2),
    .div_wait  (div_wait),
    .div_ready (div_ready),
    .div_wr    (div_wr),
    .div_rd    (div_rd)
  );

  always #5 clk = ~clk;

  function automatic bit tb_is_div(input logic [31:0] insn);
    return (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001) && insn[14];
  endfunction

  // RISC-V M-extension division semantics
  function automatic logic [31:0] ref_div(input logic [31:0] insn, input logic [31:0] a,
                                           input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (insn[14:12])
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      3'b111: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  function automatic bit any_pend();
    bit p;
    p = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && tb_is_div(req_insn[32*i +: 32])) p = 1'b1;
    end
    return p;
  endfunction

  task automatic issue(input int i, input logic [31:0] insn, input logic [31:0] a,
                       input logic [31:0] b);
    req_insn[32*i +: 32] = insn;
    req_rs1[32*i +: 32]  = a;
    req_rs2[32*i +: 32]  = b;
    req_valid[i]         = 1'b1;
    req_exp[i]           = ref_div(insn, a, b);
  endtask

  task automatic issue_random(input int i);
    logic [2:0]  f3;
    logic [31:0] a, b;
    f3 = 3'(4 + $urandom_range(0, 3));
    a  = $urandom;
    case ($urandom_range(0, 5))
      0: b = 32'h0;
      1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      2: b = $urandom;
      default: b = $urandom_range(1, 100);
    endcase
    issue(i, mk_insn(7'b0000001, f3, 7'b0110011), a, b);
  endtask

  // one clock: check outputs against the model, then advance the divider
  // and requester models
  task automatic step();
    logic [NREQ-1:0] pend, exp_rdy, exp_wait;
    int w, j;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) pend[i] = req_valid[i] && tb_is_div(req_insn[32*i +: 32]);
    if (!resetn) begin
      checks++;
      if (div_valid !== 1'b0 || div_insn !== 32'h0 || div_rs1 !== 32'h0 || div_rs2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_div_port: valid=%b insn=%h rs1=%h rs2=%h, required all zero",
                 div_valid, div_insn, div_rs1, div_rs2);
      end
      checks++;
      if (req_ready !== '0 || req_wr !== '0 || req_rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_req_port: ready=%b wr=%b rd=%h, required all zero", req_ready, req_wr, req_rd);
      end
      checks++;
      if (req_wait !== '0) begin
        errors++;
        $display("FAIL reset_wait: got %b, required 0", req_wait);
      end
      m_ptr = RR_INIT; m_active = 0; m_done_exp = 0; m_aborted = 0; prev_dv = 0;
      dm_busy = 0; dm_rdy = 0;
      div_wait = 0; div_ready = 0; div_wr = 0; div_rd = 0;
      return;
    end
    if (m_active && !req_valid[m_owner]) m_aborted = 1;
    exp_rdy = '0;
    if (m_done_exp && !m_aborted) exp_rdy[m_owner] = 1'b1;
    checks++;
    if (req_ready !== exp_rdy || req_wr !== exp_rdy) begin
      errors++;
      $display("FAIL ready_strobe: ready=%b wr=%b, required %b", req_ready, req_wr, exp_rdy);
    end
    if (exp_rdy != '0) begin
      checks++;
      if (req_rd !== req_exp[m_owner]) begin
        errors++;
        $display("FAIL result r%0d: got %h, required %h", m_owner, req_rd, req_exp[m_owner]);
      end
      comp_q.push_back(m_owner);
      comp_rd.push_back(req_rd);
    end
    for (int i = 0; i < NREQ; i++) exp_wait[i] = pend[i] && !(m_done_exp && m_owner == i);
    checks++;
    if (req_wait !== exp_wait) begin
      errors++;
      $display("FAIL req_wait: got %b, required %b", req_wait, exp_wait);
    end
    if (m_done_exp) begin
      m_ptr = (m_owner + 1) % NREQ;
      m_active = 0;
      m_done_exp = 0;
    end
    if (div_valid === 1'b1 && !prev_dv) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (w < 0 && pend[j]) w = j;
      end
      checks++;
      if (w < 0) begin
        errors++;
        $display("FAIL grant_without_request: div_insn=%h", div_insn);
      end else if (div_insn !== req_insn[32*w +: 32] || div_rs1 !== req_rs1[32*w +: 32] ||
                   div_rs2 !== req_rs2[32*w +: 32]) begin
        errors++;
        $display("FAIL grant_winner: got insn=%h rs1=%h rs2=%h, required r%0d insn=%h rs1=%h rs2=%h",
                 div_insn, div_rs1, div_rs2, w, req_insn[32*w +: 32], req_rs1[32*w +: 32],
                 req_rs2[32*w +: 32]);
      end
      m_owner = (w < 0) ? 0 : w;
      m_active = 1;
      m_aborted = 0;
      lat_insn = div_insn; lat_rs1 = div_rs1; lat_rs2 = div_rs2;
      grant_q.push_back(m_owner);
    end else if (m_active && div_valid === 1'b1) begin
      checks++;
      if (div_insn !== lat_insn || div_rs1 !== lat_rs1 || div_rs2 !== lat_rs2) begin
        errors++;
        $display("FAIL operand_hold: got %h/%h/%h, required %h/%h/%h",
                 div_insn, div_rs1, div_rs2, lat_insn, lat_rs1, lat_rs2);
      end
    end
    prev_dv = (div_valid === 1'b1);
    if (dm_rdy) begin
      checks++;
      if (div_valid !== 1'b0) begin
        errors++;
        $display("FAIL valid_after_ready: got %b, required 0", div_valid);
      end
      dm_rdy = 0; div_ready = 0; div_wr = 0;
    end else if (dm_busy) begin
      if (dm_cnt == 0) begin
        div_ready = 1; div_wr = 1; div_wait = 0;
        div_rd = ref_div(dm_insn, dm_a, dm_b);
        dm_busy = 0; dm_rdy = 1;
        m_done_exp = 1;
      end else begin
        dm_cnt--;
      end
    end else if (div_valid === 1'b1) begin
      div_wait = 1;
      dm_busy = 1;
      dm_insn = div_insn; dm_a = div_rs1; dm_b = div_rs2;
      dm_cnt = (dm_force >= 0) ? dm_force : int'($urandom_range(0, 4));
    end
    for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) req_valid[i] = 1'b0;
  endtask

  task automatic run_until_quiet(input int budget, input string name);
    int c;
    for (c = 0; c < budget; c++) begin
      step();
      if (!any_pend() && !m_active && !dm_busy && !dm_rdy) break;
    end
    checks++;
    if (c >= budget) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req_valid = '0;
    step();
    step();
    resetn = 1'b1;
    comp_q.delete();
    comp_rd.delete();
    grant_q.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    issue(0, mk_insn(7'b0000001, 3'b101, 7'b0110011), 32'd100, 32'd7);
    step();
    step();
    checks++;
    if (div_valid !== 1'b0 || req_wait !== '0) begin
      errors++;
      $display("FAIL reset_with_request: div_valid=%b req_wait=%b, required 0/0", div_valid, req_wait);
    end
    req_valid = '0;
    resetn = 1'b1;
    step();
    checks++;
    if (div_valid !== 1'b0 || req_ready !== '0 || req_wait !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: div_valid=%b ready=%b wait=%b, required all 0",
               div_valid, req_ready, req_wait);
    end
  endtask

  task automatic test_single();
    int c;
    do_reset();
    dm_force = 2;
    issue(0, mk_insn(7'b0000001, 3'b101, 7'b0110011), 32'd100, 32'd7);
    step();
    checks++;
    if (div_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_grant_latency: div_valid=%b, required 1", div_valid);
    end
    // the core scribbling on its operands must not reach the divider
    req_rs1[31:0] = 32'hDEAD_BEEF;
    req_rs2[31:0] = 32'h0;
    for (c = 0; c < 50 && div_ready !== 1'b1; c++) step();
    step();
    checks++;
    if (req_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_ready_latency: req_ready=%b, required 001", req_ready);
    end
    run_until_quiet(50, "single");
    checks++;
    if (comp_q.size() != 1 || comp_q[0] != 0 || comp_rd[0] !== 32'd14) begin
      errors++;
      $display("FAIL single_result: %0d completions, first rd=%h, required 1 completion r0 rd=0000000e",
               comp_q.size(), (comp_rd.size() > 0) ? comp_rd[0] : 32'h0);
    end
    dm_force = -1;
  endtask

  task automatic test_contention();
    do_reset();
    issue(0, mk_insn(7'b0000001, 3'b100, 7'b0110011), 32'hFFFF_FFEC, 32'd3);
    issue(1, mk_insn(7'b0000001, 3'b111, 7'b0110011), 32'd17, 32'd5);
    run_until_quiet(200, "contention");
    checks++;
    if (comp_q.size() != 2) begin
      errors++;
      $display("FAIL contention_count: got %0d completions, required 2", comp_q.size());
    end else begin
      checks++;
      if (comp_q[0] != 0 || comp_rd[0] !== 32'hFFFF_FFFA) begin
        errors++;
        $display("FAIL contention_first: got r%0d rd=%h, required r0 rd=fffffffa", comp_q[0], comp_rd[0]);
      end
      checks++;
      if (comp_q[1] != 1 || comp_rd[1] !== 32'd2) begin
        errors++;
        $display("FAIL contention_second: got r%0d rd=%h, required r1 rd=00000002", comp_q[1], comp_rd[1]);
      end
    end
  endtask

  task automatic test_fairness();
    int issued;
    int c;
    do_reset();
    for (int i = 0; i < NREQ; i++) issue_random(i);
    issued = NREQ;
    for (c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && issued < 3 * NREQ) begin
          issue_random(i);
          issued++;
        end
      end
      if (comp_q.size() >= 3 * NREQ) break;
    end
    run_until_quiet(100, "fairness");
    checks++;
    if (comp_q.size() != 3 * NREQ) begin
      errors++;
      $display("FAIL fairness_count: got %0d completions, required %0d", comp_q.size(), 3 * NREQ);
    end
    for (int k = 0; k < comp_q.size(); k++) begin
      checks++;
      if (comp_q[k] != k % NREQ) begin
        errors++;
        $display("FAIL fairness_order[%0d]: got r%0d, required r%0d", k, comp_q[k], k % NREQ);
      end
    end
  endtask

  task automatic test_nondiv();
    do_reset();
    issue(0, mk_insn(7'b0000001, 3'b000, 7'b0110011), 32'd3, 32'd4);
    issue(1, mk_insn(7'b0000000, 3'b100, 7'b0110011), 32'd9, 32'd2);
    issue(2, mk_insn(7'b0000001, 3'b101, 7'b0010011), 32'd9, 32'd2);
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (div_valid !== 1'b0 || req_wait !== '0 || req_ready !== '0) begin
        errors++;
        $display("FAIL nondiv: div_valid=%b wait=%b ready=%b, required all 0", div_valid, req_wait, req_ready);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_abort();
    int c;
    do_reset();
    dm_force = 6;
    issue_random(1);
    for (c = 0; c < 20 && !dm_busy; c++) step();
    step();
    step();
    issue_random(0);
    step();
    req_valid[1] = 1'b0;
    dm_force = -1;
    run_until_quiet(200, "abort");
    checks++;
    if (comp_q.size() != 1 || comp_q[0] != 0) begin
      errors++;
      $display("FAIL abort_completions: got %0d completions first r%0d, required 1 completion r0",
               comp_q.size(), (comp_q.size() > 0) ? comp_q[0] : -1);
    end
    checks++;
    if (grant_q.size() != 2 || grant_q[0] != 1 || grant_q[1] != 0) begin
      errors++;
      $display("FAIL abort_grants: got %0d grants, required r1 then r0", grant_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    do_reset();
    dm_force = 6;
    issue_random(0);
    for (int c = 0; c < 4; c++) step();
    resetn = 1'b0;
    req_valid = '0;
    step();
    checks++;
    if (div_valid !== 1'b0 || div_insn !== 32'h0 || req_ready !== '0 || req_wait !== '0) begin
      errors++;
      $display("FAIL reset_mid: div_valid=%b insn=%h ready=%b wait=%b, required all 0",
               div_valid, div_insn, req_ready, req_wait);
    end
    resetn = 1'b1;
    dm_force = -1;
    comp_q.delete();
    comp_rd.delete();
    issue_random(2);
    exp = req_exp[2];
    run_until_quiet(100, "reset_mid");
    checks++;
    if (comp_q.size() != 1 || comp_q[0] != 2 || comp_rd[0] !== exp) begin
      errors++;
      $display("FAIL reset_mid_fresh: got %0d completions rd=%h, required r2 rd=%h",
               comp_q.size(), (comp_rd.size() > 0) ? comp_rd[0] : 32'h0, exp);
    end
  endtask

  initial begin
    req_valid = '0;
    req_insn  = '0;
    req_rs1   = '0;
    req_rs2   = '0;
    div_wait  = 1'b0;
    div_ready = 1'b0;
    div_wr    = 1'b0;
    div_rd    = 32'h0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_nondiv();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
